// File: rtl/fft_src_pkg.sv
// rtl/fft_src_pkg.sv - shared types, constants and sample conversion for fft_frame_src
package fft_src_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  localparam int DEF_FRAME_LEN = 1024;
  localparam int DEF_DATA_W    = 10;
  localparam int ADC_OFFSET    = 1 << (DEF_DATA_W - 1);

  // Subtracting the mid-scale offset equals flipping the sample MSB; the result
  // is then placed at the top of the 16-bit word so full scale spans Q15.
  function automatic logic [15:0] to_q15(input logic [15:0] raw, input int dw);
    logic [15:0] flipped;
    flipped = raw ^ (16'd1 << (dw - 1));
    return flipped << (16 - dw);
  endfunction

endpackage

// File: rtl/fft_src_fifo.sv
// rtl/fft_src_fifo.sv - synchronous show-ahead FIFO; head word is visible on rd_data
module fft_src_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  // A write into a full FIFO is fine when the head leaves in the same cycle.
  assign do_wr = wr_en && (!full || rd_en);
  assign do_rd = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fft_frame_src.sv
// rtl/fft_frame_src.sv - ADC capture to fixed-length AXI-Stream frames for the FFT core
module fft_frame_src
  import fft_src_pkg::*;
#(
  parameter int FRAME_LEN    = DEF_FRAME_LEN,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int FIFO_DEPTH   = 16,
  parameter bit CONT_DEFAULT = 1'b0
) (
  input  logic                         fft_clk,
  input  logic                         sys_rst_n,
  input  logic [DATA_W-1:0]            ad_data,
  input  logic                         ad_valid,
  input  logic                         start,
  input  logic                         cont,
  output logic [31:0]                  m_axis_tdata,
  output logic                         m_axis_tvalid,
  output logic                         m_axis_tlast,
  input  logic                         m_axis_tready,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         overflow,
  output logic [$clog2(FRAME_LEN)-1:0] beat_idx
);

  localparam int IW = $clog2(FRAME_LEN);
  localparam int CW = IW + 1;

  state_t        state;
  state_t        state_nxt;
  logic          cont_r;
  logic [CW-1:0] in_cnt;
  logic [IW-1:0] out_cnt;
  logic          tvalid_r;
  logic [15:0]   real_r;

  logic          fifo_full;
  logic          fifo_empty;
  logic [15:0]   fifo_dout;
  logic          fifo_wr;
  logic          fifo_rd;
  logic          accept;
  logic          drop;
  logic          hs;
  logic          last_hs;
  logic          arm;
  logic          rearm;

  assign accept  = (state == ST_RUN) && ad_valid;
  assign fifo_rd = !fifo_empty && (!tvalid_r || m_axis_tready);
  assign fifo_wr = accept && (!fifo_full || fifo_rd);
  assign drop    = accept && fifo_full && !fifo_rd;
  assign hs      = tvalid_r && m_axis_tready;
  assign last_hs = hs && (out_cnt == IW'(FRAME_LEN - 1));

  // Samples are converted before buffering so the FIFO holds ready-to-send words.
  fft_src_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk     (fft_clk),
    .rst_n   (sys_rst_n),
    .wr_en   (fifo_wr),
    .wr_data (to_q15(16'(ad_data), DATA_W)),
    .rd_en   (fifo_rd),
    .rd_data (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    arm       = 1'b0;
    rearm     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_RUN;
          arm       = 1'b1;
        end
      end
      ST_RUN: begin
        if (fifo_wr && (in_cnt == CW'(FRAME_LEN - 1))) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (last_hs) begin
          if (cont_r) begin
            state_nxt = ST_RUN;
            rearm     = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge fft_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      cont_r     <= CONT_DEFAULT;
      in_cnt     <= '0;
      out_cnt    <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
      tvalid_r   <= 1'b0;
      real_r     <= '0;
    end else begin
      state      <= state_nxt;
      frame_done <= last_hs && (state == ST_DRAIN);
      if (arm) cont_r <= cont;

      if (arm) overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;

      if (arm || rearm) in_cnt <= '0;
      else if (fifo_wr) in_cnt <= in_cnt + 1'b1;

      if (arm || rearm) out_cnt <= '0;
      else if (hs) out_cnt <= out_cnt + 1'b1;

      // The output register only changes on a load or after its beat is taken.
      if (fifo_rd) begin
        tvalid_r <= 1'b1;
        real_r   <= fifo_dout;
      end else if (m_axis_tready) begin
        tvalid_r <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = {16'h0000, real_r};
  assign m_axis_tvalid = tvalid_r;
  assign m_axis_tlast  = tvalid_r && (out_cnt == IW'(FRAME_LEN - 1));
  assign beat_idx      = out_cnt;
  assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_fft_frame_src.sv
// tb/tb_fft_frame_src.sv - directed checks of framing, conversion, stalls, overflow and reset
module tb_fft_frame_src;

  localparam int FL = 8;
  localparam int DW = 10;
  localparam int FD = 4;

  logic          fft_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic [DW-1:0] ad_data = '0;
  logic          ad_valid = 1'b0;
  logic          start = 1'b0;
  logic          cont = 1'b0;
  logic          m_axis_tready = 1'b0;
  logic [31:0]   m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          busy;
  logic          frame_done;
  logic          overflow;
  logic [2:0]    beat_idx;

  fft_frame_src #(
    .FRAME_LEN    (FL),
    .DATA_W       (DW),
    .FIFO_DEPTH   (FD),
    .CONT_DEFAULT (1'b0)
  ) dut (
    .fft_clk       (fft_clk),
    .sys_rst_n     (sys_rst_n),
    .ad_data       (ad_data),
    .ad_valid      (ad_valid),
    .start         (start),
    .cont          (cont),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .frame_done    (frame_done),
    .overflow      (overflow),
    .beat_idx      (beat_idx)
  );

  always #5 fft_clk = ~fft_clk;

  typedef struct {
    logic [DW-1:0] din;
    logic [15:0]   q;
  } vec_t;

  vec_t        vecs [8];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          fd_cnt = 0;
  int          bidx = 0;
  logic        pat_on = 1'b0;
  logic [31:0] beat_q [$];
  int          hc_q [$];
  logic [15:0] exp_q [$];

  always @(posedge fft_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge fft_clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    ad_data  = d;
    ad_valid = 1'b1;
    step();
    ad_valid = 1'b0;
  endtask

  task automatic do_start(input logic c);
    start = 1'b1;
    cont  = c;
    step();
    start = 1'b0;
    cont  = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int k;
    k = 0;
    while (beat_q.size() < n && k < 300) begin
      @(negedge fft_clk);
      k++;
    end
    chk("beat_count", 32'(beat_q.size()), 32'(n));
  endtask

  task automatic check_beats(input string name);
    wait_beats(exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < beat_q.size()) chk(name, beat_q[i], {16'h0000, exp_q[i]});
    end
  endtask

  task automatic clear_q();
    beat_q.delete();
    hc_q.delete();
    exp_q.delete();
  endtask

  // Output monitor: ordering, beat index, tlast position, stall stability, frame_done timing.
  initial begin
    logic        stall_p;
    logic        tl_p;
    logic [31:0] pd;
    logic        pl;
    stall_p = 1'b0;
    tl_p    = 1'b0;
    pd      = '0;
    pl      = 1'b0;
    forever begin
      @(negedge fft_clk);
      if (!sys_rst_n) begin
        bidx    = 0;
        stall_p = 1'b0;
        tl_p    = 1'b0;
      end else begin
        if (stall_p) begin
          chk("stall_tvalid", 32'(m_axis_tvalid), 32'(1));
          chk("stall_tdata", m_axis_tdata, pd);
          chk("stall_tlast", 32'(m_axis_tlast), 32'(pl));
        end
        if (tl_p || frame_done) chk("frame_done_timing", 32'(frame_done), 32'(tl_p));
        if (frame_done) fd_cnt++;
        tl_p = 1'b0;
        if (m_axis_tvalid && m_axis_tready) begin
          chk("beat_idx", 32'(beat_idx), 32'(bidx));
          chk("tlast_pos", 32'(m_axis_tlast), 32'(bidx == FL - 1));
          beat_q.push_back(m_axis_tdata);
          hc_q.push_back(cyc);
          tl_p = (bidx == FL - 1);
          bidx = (bidx + 1) % FL;
        end
        stall_p = m_axis_tvalid && !m_axis_tready;
        pd      = m_axis_tdata;
        pl      = m_axis_tlast;
      end
    end
  end

  initial begin
    forever begin
      @(posedge fft_clk);
      #1;
      if (pat_on) m_axis_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int k;
    vecs[0] = '{10'h200, 16'h0000};
    vecs[1] = '{10'h3FF, 16'h7FC0};
    vecs[2] = '{10'h000, 16'h8000};
    vecs[3] = '{10'h201, 16'h0040};
    vecs[4] = '{10'h202, 16'h0080};
    vecs[5] = '{10'h203, 16'h00C0};
    vecs[6] = '{10'h204, 16'h0100};
    vecs[7] = '{10'h205, 16'h0140};

    // reset state
    step();
    step();
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'(0));
    chk("rst_tlast", 32'(m_axis_tlast), 32'(0));
    chk("rst_tdata", m_axis_tdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_frame_done", 32'(frame_done), 32'(0));
    chk("rst_overflow", 32'(overflow), 32'(0));
    chk("rst_beat_idx", 32'(beat_idx), 32'(0));
    sys_rst_n = 1'b1;
    step();

    // single frame, full rate
    m_axis_tready = 1'b1;
    do_start(1'b0);
    chk("t1_busy", 32'(busy), 32'(1));
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].din);
      exp_q.push_back(vecs[i].q);
    end
    check_beats("t1_data");
    if (hc_q.size() == 8) begin
      chk("t1_latency", 32'(hc_q[0] - c0), 32'(2));
      for (int i = 1; i < 8; i++) chk("t1_throughput", 32'(hc_q[i] - hc_q[i-1]), 32'(1));
    end
    repeat (3) step();
    chk("t1_busy_end", 32'(busy), 32'(0));
    chk("t1_overflow", 32'(overflow), 32'(0));
    chk("t1_frames", 32'(fd_cnt), 32'(1));
    clear_q();

    // tready 1-0-0-1 pattern, samples every other cycle
    pat_on = 1'b1;
    do_start(1'b0);
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].din);
      step();
      exp_q.push_back(vecs[i].q);
    end
    check_beats("t2_data");
    pat_on = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) step();
    chk("t2_overflow", 32'(overflow), 32'(0));
    chk("t2_busy_end", 32'(busy), 32'(0));
    chk("t2_frames", 32'(fd_cnt), 32'(2));
    clear_q();

    // stalled sink: 6 samples into 4-deep FIFO plus output register
    m_axis_tready = 1'b0;
    do_start(1'b0);
    for (int i = 0; i < 6; i++) send(vecs[i].din);
    repeat (4) step();
    chk("t3_overflow", 32'(overflow), 32'(1));
    chk("t3_hold_tvalid", 32'(m_axis_tvalid), 32'(1));
    chk("t3_hold_tdata", m_axis_tdata, {16'h0000, vecs[0].q});
    chk("t3_hold_idx", 32'(beat_idx), 32'(0));
    m_axis_tready = 1'b1;
    send(vecs[6].din);
    send(vecs[7].din);
    send(10'h3FF);
    for (int i = 0; i < 5; i++) exp_q.push_back(vecs[i].q);
    exp_q.push_back(vecs[6].q);
    exp_q.push_back(vecs[7].q);
    exp_q.push_back(16'h7FC0);
    check_beats("t3_data");
    repeat (3) step();
    chk("t3_beats_exact", 32'(beat_q.size()), 32'(8));
    chk("t3_overflow_sticky", 32'(overflow), 32'(1));
    chk("t3_busy_end", 32'(busy), 32'(0));
    chk("t3_frames", 32'(fd_cnt), 32'(3));
    clear_q();

    // start and cont pulsed mid-frame are ignored
    do_start(1'b0);
    chk("t5_overflow_cleared", 32'(overflow), 32'(0));
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        start = 1'b1;
        cont  = 1'b1;
      end
      send(vecs[i].din);
      start = 1'b0;
      cont  = 1'b0;
      exp_q.push_back(vecs[i].q);
    end
    check_beats("t5_data");
    repeat (3) step();
    chk("t5_beats_exact", 32'(beat_q.size()), 32'(8));
    chk("t5_busy_end", 32'(busy), 32'(0));
    chk("t5_frames", 32'(fd_cnt), 32'(4));
    clear_q();

    // continuous mode: 24 strobes every third cycle make three frames
    do_start(1'b1);
    for (int i = 0; i < 24; i++) begin
      chk("t4_busy", 32'(busy), 32'(1));
      send(vecs[i % 8].din);
      step();
      step();
      exp_q.push_back(vecs[i % 8].q);
    end
    check_beats("t4_data");
    repeat (3) step();
    chk("t4_frames", 32'(fd_cnt), 32'(7));
    chk("t4_busy_after", 32'(busy), 32'(1));
    clear_q();

    // reset asserted while beat 3 is on the bus
    m_axis_tready = 1'b0;
    for (int i = 0; i < 6; i++) send(vecs[i].din);
    chk("t6_overflow_set", 32'(overflow), 32'(1));
    m_axis_tready = 1'b1;
    k = 0;
    while (!(m_axis_tvalid && beat_idx == 3'd3) && k < 50) begin
      @(negedge fft_clk);
      k++;
    end
    chk("t6_reach_beat3", 32'(k < 50), 32'(1));
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("t6_tvalid", 32'(m_axis_tvalid), 32'(0));
    chk("t6_busy", 32'(busy), 32'(0));
    chk("t6_overflow", 32'(overflow), 32'(0));
    chk("t6_beat_idx", 32'(beat_idx), 32'(0));
    step();
    step();
    sys_rst_n = 1'b1;
    step();
    clear_q();
    chk("t6_no_frame_done", 32'(fd_cnt), 32'(7));
    do_start(1'b0);
    for (int i = 7; i >= 0; i--) begin
      send(vecs[i].din);
      exp_q.push_back(vecs[i].q);
    end
    check_beats("t6_data");
    repeat (3) step();
    chk("t6_beats_exact", 32'(beat_q.size()), 32'(8));
    chk("t6_frames", 32'(fd_cnt), 32'(8));
    chk("t6_busy_end", 32'(busy), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
